// File: rtl/vector_check_ctrl.sv
// Self-test sequencer: replays {valid, in, exp} vectors from a small memory into a
// combinational datapath and counts mismatches. Define VCHK_STOP_ON_ERR_EN to end a run at the first mismatch.
module vector_check_ctrl #(
    parameter int NIN        = 3,
    parameter int NOUT       = 1,
    parameter int DEPTH      = 16,
    parameter int AW         = 4,
    parameter int SETTLE_CYC = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            vec_we,
    input  logic [AW-1:0]   vec_addr,
    input  logic [NIN+NOUT:0] vec_wdata,
    input  logic            start,
    output logic [NIN-1:0]  dut_in,
    input  logic [NOUT-1:0] dut_out,
    output logic            busy,
    output logic            done,
    output logic            fail,
    output logic [AW:0]     vec_count,
    output logic [15:0]     err_count,
    output logic [AW-1:0]   first_err_idx
);

`ifdef VCHK_STOP_ON_ERR_EN
    localparam bit STOP_ON_ERR = 1'b1;
`else
    localparam bit STOP_ON_ERR = 1'b0;
`endif

    localparam int EW = 1 + NIN + NOUT;

    typedef enum logic [2:0] {IDLE, LOAD, APPLY, SETTLE, CHECK, FINISH} state_t;

    state_t          state;
    logic [AW-1:0]   ptr;
    logic [3:0]      settle_cnt;
    logic [EW-1:0]   mem [DEPTH];
    logic [EW-1:0]   ent;
    logic            ent_vld;
    logic [NIN-1:0]  ent_in;
    logic [NOUT-1:0] ent_exp;
    logic            mismatch;

    // Memory is frozen while busy, so the entry at ptr can be re-read in every state of a vector.
    assign ent      = mem[ptr];
    assign ent_vld  = ent[EW-1];
    assign ent_in   = ent[NIN+NOUT-1:NOUT];
    assign ent_exp  = ent[NOUT-1:0];
    assign mismatch = (dut_out != ent_exp);

    always_ff @(posedge clk) begin
        if (vec_we && !busy)
            mem[vec_addr] <= vec_wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            ptr           <= '0;
            settle_cnt    <= '0;
            dut_in        <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            fail          <= 1'b0;
            vec_count     <= '0;
            err_count     <= '0;
            first_err_idx <= '0;
        end else begin
            case (state)
                IDLE, FINISH: begin
                    if (start) begin
                        done          <= 1'b0;
                        fail          <= 1'b0;
                        vec_count     <= '0;
                        err_count     <= '0;
                        first_err_idx <= '0;
                        ptr           <= '0;
                        busy          <= 1'b1;
                        state         <= LOAD;
                    end
                end
                LOAD: begin
                    if (!ent_vld) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FINISH;
                    end else begin
                        state <= APPLY;
                    end
                end
                APPLY: begin
                    dut_in     <= ent_in;
                    settle_cnt <= 4'(SETTLE_CYC);
                    state      <= SETTLE;
                end
                SETTLE: begin
                    if (settle_cnt <= 4'd1)
                        state <= CHECK;
                    else
                        settle_cnt <= settle_cnt - 4'd1;
                end
                CHECK: begin
                    if (mismatch) begin
                        if (err_count != 16'hFFFF)
                            err_count <= err_count + 16'd1;
                        if (!fail) begin
                            fail          <= 1'b1;
                            first_err_idx <= ptr;
                        end
                    end
                    vec_count <= vec_count + 1'b1;
                    // Last slot ends the run; the pointer never wraps back to 0.
                    if (ptr == AW'(DEPTH - 1) || (STOP_ON_ERR && mismatch)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FINISH;
                    end else begin
                        ptr   <= ptr + 1'b1;
                        state <= LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vector_check_ctrl.sv
// Bench for vector_check_ctrl: directed scenarios plus a run-level model that
// predicts busy/done/dut_in every cycle and the final counters of each run.
module tb_vector_check_ctrl;

`ifdef VCHK_STOP_ON_ERR_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       vec_we;
    logic [3:0] vec_addr;
    logic [4:0] vec_wdata;
    logic       start;
    logic [2:0] dut_in;
    logic [0:0] dut_out;
    logic       busy, done, fail;
    logic [4:0] vec_count;
    logic [15:0] err_count;
    logic [3:0] first_err_idx;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Datapath under test: y = ~b&~c | a&~b
    assign dut_out = (~dut_in[1] & ~dut_in[0]) | (dut_in[2] & ~dut_in[1]);

    vector_check_ctrl dut (
        .clk(clk), .reset(reset), .vec_we(vec_we), .vec_addr(vec_addr),
        .vec_wdata(vec_wdata), .start(start), .dut_in(dut_in), .dut_out(dut_out),
        .busy(busy), .done(done), .fail(fail), .vec_count(vec_count),
        .err_count(err_count), .first_err_idx(first_err_idx)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic fref(input logic [2:0] abc);
        return (~abc[1] & ~abc[0]) | (abc[2] & ~abc[1]);
    endfunction

    // ---------------- run-level model ----------------
    logic [4:0] mem_m [16];
    logic [2:0] vin [16];
    int  m_n, m_errs, m_first, m_len, m_cyc;
    bit  m_fail, m_run, m_was_busy;
    logic [2:0] m_hold, m_now;

    function automatic logic [2:0] exp_din();
        int j;
        if (!m_run || m_n == 0 || m_cyc < 2) return m_hold;
        j = (m_cyc - 2) / 4;
        if (j >= m_n) j = m_n - 1;
        return vin[j];
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_run = 0; m_cyc = 0; m_hold = '0; m_n = 0; m_errs = 0;
            m_first = 0; m_fail = 0; m_len = 0;
        end else begin
            m_was_busy = m_run && (m_cyc < m_len);
            m_now = exp_din();
            if (m_run) m_cyc++;
            if (vec_we && !m_was_busy) mem_m[vec_addr] = vec_wdata;
            if (start && !m_was_busy) begin
                bit inval;
                m_hold = m_now; m_n = 0; m_errs = 0; m_first = 0; m_fail = 0; inval = 0;
                for (int i = 0; i < 16; i++) begin
                    if (mem_m[i][4] !== 1'b1) begin inval = 1; break; end
                    vin[m_n] = mem_m[i][3:1];
                    m_n++;
                    if (fref(mem_m[i][3:1]) != mem_m[i][0]) begin
                        if (!m_fail) m_first = i;
                        m_fail = 1;
                        m_errs++;
                        if (STOP) break;
                    end
                end
                m_len = 4 * m_n + (inval ? 1 : 0);
                m_cyc = 0;
                m_run = 1;
            end
        end
    end

    always @(negedge clk) begin
        bit e_done;
        e_done = m_run && (m_cyc >= m_len);
        chk("busy", 32'(busy), 32'(m_run && (m_cyc < m_len)));
        chk("done", 32'(done), 32'(e_done));
        chk("dut_in", 32'(dut_in), 32'(exp_din()));
        if (e_done) begin
            chk("vec_count", 32'(vec_count), 32'(m_n));
            chk("err_count", 32'(err_count), 32'(m_errs));
            chk("fail", 32'(fail), 32'(m_fail));
            if (m_fail) chk("first_err_idx", 32'(first_err_idx), 32'(m_first));
        end else if (!m_run) begin
            chk("idle_vec_count", 32'(vec_count), 32'd0);
            chk("idle_err_count", 32'(err_count), 32'd0);
            chk("idle_fail", 32'(fail), 32'd0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic wr(input logic [3:0] a, input logic [4:0] d);
        @(negedge clk);
        vec_we = 1'b1; vec_addr = a; vec_wdata = d;
        @(negedge clk);
        vec_we = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // k counts edges after the start edge; returns the edge after which done was seen.
    task automatic wait_done(input int k0, output int k);
        k = k0;
        while (!done && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (k >= 300) begin
            fails++; tests++;
            $display("FAIL done_timeout: got no done expected done within 300 cycles");
        end
    endtask

    task automatic load_truth(input int base);
        for (int i = 0; i < 8; i++) begin
            logic [2:0] abc;
            abc = 3'(i);
            wr(4'(base + i), {1'b1, abc, fref(abc)});
        end
    endtask

    int k;

    initial begin
        reset = 1'b1; vec_we = 0; vec_addr = 0; vec_wdata = 0; start = 0;
        #12;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_dut_in", 32'(dut_in), 32'd0);
        reset = 1'b0;

        // Invalid entry 0: run ends after the LOAD edge with nothing checked.
        wr(4'd0, 5'b0_000_0);
        pulse_start();
        wait_done(0, k);
        chk("s3_cycles", 32'(k), 32'd1);
        chk("s3_vec_count", 32'(vec_count), 32'd0);
        chk("s3_dut_in", 32'(dut_in), 32'd0);

        // Full truth table, address 8 invalid.
        load_truth(0);
        wr(4'd8, 5'b0_000_0);
        pulse_start();
        wait_done(0, k);
        chk("s1_cycles", 32'(k), 32'd33);
        chk("s1_vec_count", 32'(vec_count), 32'd8);
        chk("s1_err_count", 32'(err_count), 32'd0);
        chk("s1_fail", 32'(fail), 32'd0);
        chk("s1_dut_in", 32'(dut_in), 32'd7);

        // Corrupt expected values at 2 and 5.
        wr(4'd2, 5'b1_010_1);
        wr(4'd5, 5'b1_101_0);
        pulse_start();
        wait_done(0, k);
        chk("s2_fail", 32'(fail), 32'd1);
        chk("s2_first_err_idx", 32'(first_err_idx), 32'd2);
        chk("s2_err_count", 32'(err_count), STOP ? 32'd1 : 32'd2);
        chk("s2_vec_count", 32'(vec_count), STOP ? 32'd3 : 32'd8);
        chk("s2_cycles", 32'(k), STOP ? 32'd12 : 32'd33);
        wr(4'd2, 5'b1_010_0);
        wr(4'd5, 5'b1_101_1);

        // start and a memory write mid-run are both ignored.
        pulse_start();
        repeat (10) @(negedge clk);
        start = 1'b1; vec_we = 1'b1; vec_addr = 4'd0; vec_wdata = 5'b1_000_0;
        @(negedge clk);
        start = 1'b0; vec_we = 1'b0;
        wait_done(11, k);
        chk("s6_cycles", 32'(k), 32'd33);
        chk("s6_err_count", 32'(err_count), 32'd0);
        chk("s6_vec_count", 32'(vec_count), 32'd8);
        pulse_start();
        wait_done(0, k);
        chk("s6_rerun_err_count", 32'(err_count), 32'd0);

        // Async reset during SETTLE of vector 3.
        pulse_start();
        repeat (14) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("s5_busy", 32'(busy), 32'd0);
        chk("s5_dut_in", 32'(dut_in), 32'd0);
        chk("s5_vec_count", 32'(vec_count), 32'd0);
        chk("s5_done", 32'(done), 32'd0);
        #1 reset = 1'b0;
        pulse_start();
        wait_done(0, k);
        chk("s5_rerun_cycles", 32'(k), 32'd33);
        chk("s5_rerun_vec_count", 32'(vec_count), 32'd8);

        // All 16 entries valid: stops after slot 15 without wrapping.
        load_truth(8);
        pulse_start();
        wait_done(0, k);
        chk("s4_cycles", 32'(k), 32'd64);
        chk("s4_vec_count", 32'(vec_count), 32'd16);
        chk("s4_err_count", 32'(err_count), 32'd0);
        repeat (3) @(negedge clk);
        chk("s4_dut_in_hold", 32'(dut_in), 32'd7);
        chk("s4_busy_after", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
